bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port of the 128x16384 dual-port activation/weight BRAM between two requesters: req0 = DMA/AXI loader, req1 = systolic array / accumulator fetch.
- Round-robin arbitration with burst locking.
- Drives the BRAM port signals and routes registered read data back to the issuing requester with a fixed latency.
- Sits directly between the requesters and the BRAM; one instance per BRAM port.

Parameters:
- ADDR_W, 14, BRAM address width (16384 words).
- DATA_W, 128, BRAM word width.
- RD_LATENCY, 1, BRAM read latency in cycles (legal 1..3).

Ports:
- clock  in  1  single clock for block and BRAM port.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 beat valid.
- req0_ready  out  1  requester 0 beat accepted this cycle.
- req0_write  in  1  1 = write, 0 = read.
- req0_last  in  1  final beat of a burst (releases lock).
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- req1_valid / req1_ready / req1_write / req1_last / req1_addr / req1_wdata: same as req0, for requester 1.
- bram_en  out  1  port enable.
- bram_we  out  1  port write enable.
- bram_addr  out  ADDR_W  port address.
- bram_din  out  DATA_W  port write data.
- bram_dout  in  DATA_W  port registered read data.
- rsp_valid  out  1  read data valid.
- rsp_id  out  1  requester that issued the read.
- rsp_data  out  DATA_W  read data (bram_dout passthrough).
- busy  out  1  burst lock held.
- grant_id  out  1  current or last owner.

Behaviour:
- Reset (sync, high): state=IDLE, priority pointer → req0 first, grant_id=0, response pipe cleared. While reset is high: req*_ready=0, bram_en=0, bram_we=0, rsp_valid=0, busy=0.
- Accept: a beat is accepted when reqN_valid && reqN_ready in the same cycle.
- Port drive: in the accept cycle, bram_en=1, bram_we=reqN_write, and bram_addr/bram_din=reqN fields, combinationally from the winner. With no accept: bram_en=0, bram_we=0; addr/din are don't-care but held at the last accepted values.
- At most one accept per cycle; req0_ready and req1_ready are never both 1.
- FSM, IDLE:
  - winner = valid requester; if both valid, the pointer's favoured one wins.
  - Winner's ready=1.
  - Accept with last=1 → stay IDLE.
  - Accept with last=0 → BURST, owner=winner, busy=1 from next cycle.
  - Any accept sets the pointer to favour the other requester next.
- FSM, BURST:
  - Only the owner may be ready; ready=owner_valid; the other requester's ready=0 regardless of its valid.
  - Owner valid low → bubble (bram_en=0), lock held indefinitely.
  - Owner accept with last=1 → IDLE, busy=0 next cycle.
- Read response:
  - Accepted read at cycle t → rsp_valid=1 at cycle t+RD_LATENCY, with rsp_id=issuer and rsp_data=bram_dout.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses, in order.
  - No response backpressure: requesters must always sink rsp.
- Read-after-write to the same address (consecutive accepts): the read returns the new data, because the BRAM port is read-first on the same cycle only.
- Reset mid-burst or with reads in flight: lock dropped, in-flight responses discarded (rsp_valid=0 from the cycle after reset asserts).
- grant_id updates on every accept; holds when idle.

Decomposition:
- Package bram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - state enum {IDLE, BURST}.
  - requester-id typedef (1 bit).
  - request struct {write, last, addr, wdata}.
- Sub-module bram_arb_rsp_pipe: RD_LATENCY-deep shift register of {valid, id}, sync clear on reset.

Test Plan:
- Only req0 valid, single read, addr 0x0005, last=1, BRAM preloaded 0xA5.. → req0_ready same cycle; bram_en=1, bram_we=0, bram_addr=0x0005; one cycle later rsp_valid=1, rsp_id=0, rsp_data=0xA5...
- Both valid continuously, all last=1 → grants alternate 0,1,0,1; with pointer starting at req0, never two consecutive grants to one requester.
- req1 burst of 4 writes (addr 0x100..0x103, last on beat 4) while req0 holds a pending read → req0_ready=0 for all 4 beats, busy=1 after beat 1; req0 granted the cycle after beat 4.
- req0 burst with owner valid dropped for 3 cycles mid-burst → bram_en=0 for those cycles, busy stays 1, req1_ready stays 0.
- Write 0xDEAD.. to 0x3FFF, then read 0x3FFF next cycle (top address) → rsp_data=0xDEAD..; then 3 back-to-back reads from both requesters → 3 consecutive rsp_valid with correct rsp_id order.
- Assert reset with a read accepted in the previous cycle, mid-burst → no rsp_valid; busy=0; after release, req0 wins the first simultaneous request.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: default widths, FSM states,
// requester id and the per-requester request bundle.
package bram_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    // Sized to the default widths; narrower instances zero-extend into it.
    typedef struct packed {
        logic                  write;
        logic                  last;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } bram_req_t;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/bram_arb_rsp_pipe.sv
// Read-response tracker: delays {valid, id} of each accepted read by the
// BRAM read latency so it lines up with bram_dout.
module bram_arb_rsp_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic valid_reg [DEPTH];
    logic id_reg    [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
                id_reg[i]    <= 1'b0;
            end
        end else begin
            valid_reg[0] <= in_valid;
            id_reg[0]    <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                id_reg[i]    <= id_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_id    = id_reg[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter with burst locking for one BRAM port;
// read data is returned to the issuer after the fixed BRAM read latency.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic              req0_last,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic              req1_last,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              grant_id
);

    bram_req_t   req [2];
    bram_req_t   win_req;
    logic [1:0]  valid;
    logic [1:0]  ready;

    arb_state_t  state_reg;
    req_id_t     owner_reg;
    req_id_t     favour_reg;
    req_id_t     grant_reg;
    logic        busy_reg;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] din_hold_reg;

    req_id_t     winner;
    logic        win_valid;
    logic        accept;
    logic        pipe_valid;
    logic        pipe_id;

    assign valid  = {req1_valid, req0_valid};
    assign req[0] = '{write: req0_write, last: req0_last,
                      addr: ADDR_W_DEF'(req0_addr), wdata: DATA_W_DEF'(req0_wdata)};
    assign req[1] = '{write: req1_write, last: req1_last,
                      addr: ADDR_W_DEF'(req1_addr), wdata: DATA_W_DEF'(req1_wdata)};

    // During a burst only the owner is considered; its valid alone decides.
    always_comb begin
        winner    = favour_reg;
        win_valid = 1'b0;
        if (state_reg == BURST) begin
            winner    = owner_reg;
            win_valid = valid[owner_reg];
        end else if (valid == 2'b11) begin
            winner    = favour_reg;
            win_valid = 1'b1;
        end else if (valid[0]) begin
            winner    = 1'b0;
            win_valid = 1'b1;
        end else if (valid[1]) begin
            winner    = 1'b1;
            win_valid = 1'b1;
        end
    end

    assign accept  = win_valid && !reset;
    assign win_req = req[winner];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready[gi] = accept && (winner == req_id_t'(gi));
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    assign bram_en   = accept;
    assign bram_we   = accept && win_req.write;
    assign bram_addr = accept ? win_req.addr[ADDR_W-1:0]  : addr_hold_reg;
    assign bram_din  = accept ? win_req.wdata[DATA_W-1:0] : din_hold_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            favour_reg    <= 1'b0;
            grant_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            addr_hold_reg <= '0;
            din_hold_reg  <= '0;
        end else if (accept) begin
            favour_reg    <= other_id(winner);
            grant_reg     <= winner;
            owner_reg     <= winner;
            addr_hold_reg <= win_req.addr[ADDR_W-1:0];
            din_hold_reg  <= win_req.wdata[DATA_W-1:0];
            case (state_reg)
                IDLE: begin
                    if (!win_req.last) begin
                        state_reg <= BURST;
                        busy_reg  <= 1'b1;
                    end
                end
                BURST: begin
                    if (win_req.last) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg && !reset;
    assign grant_id = reset ? 1'b0 : (accept ? winner : grant_reg);

    bram_arb_rsp_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_rsp_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_valid (accept && !win_req.write),
        .in_id    (winner),
        .out_valid(pipe_valid),
        .out_id   (pipe_id)
    );

    // Responses in flight when reset rises are suppressed immediately.
    assign rsp_valid = pipe_valid && !reset;
    assign rsp_id    = pipe_id;
    assign rsp_data  = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, per-cycle scoreboard against a
// rule-level arbitration model, and directed scenarios with literal checks.
module tb_bram_port_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 128;
    localparam int RD_LATENCY = 1;
    localparam int WORDS      = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              req0_valid, req0_ready, req0_write, req0_last;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_write, req1_last;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              bram_en, bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din, bram_dout;
    logic              rsp_valid, rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              busy, grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    bram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_write(req0_write),
        .req0_last (req0_last),
        .req0_addr (req0_addr),
        .req0_wdata(req0_wdata),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_write(req1_write),
        .req1_last (req1_last),
        .req1_addr (req1_addr),
        .req1_wdata(req1_wdata),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-first BRAM port with RD_LATENCY-cycle registered output.
    logic [DATA_W-1:0] mem     [WORDS];
    logic [DATA_W-1:0] rd_pipe [RD_LATENCY];
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            rd_pipe[0] <= mem[bram_addr];
        end
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[RD_LATENCY-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        int                due;
        bit                id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] shadow [WORDS];
    rsp_t rsp_q[$];
    int   cyc        = 0;
    int   lock_owner = -1;
    int   favour     = 0;
    int   last_grant = 0;

    always @(negedge clock) begin : model
        bit                v [2];
        bit                w [2];
        bit                l [2];
        logic [ADDR_W-1:0] a [2];
        logic [DATA_W-1:0] d [2];
        bit                e_acc;
        int                e_id;
        bit                e_rv;
        rsp_t              r;

        cyc++;
        v[0] = req0_valid; w[0] = req0_write; l[0] = req0_last; a[0] = req0_addr; d[0] = req0_wdata;
        v[1] = req1_valid; w[1] = req1_write; l[1] = req1_last; a[1] = req1_addr; d[1] = req1_wdata;

        e_acc = 1'b0;
        e_id  = 0;
        if (!reset) begin
            if (lock_owner >= 0) begin
                e_id  = lock_owner;
                e_acc = v[lock_owner];
            end else if (v[0] && v[1]) begin
                e_id  = favour;
                e_acc = 1'b1;
            end else if (v[0] || v[1]) begin
                e_id  = v[0] ? 0 : 1;
                e_acc = 1'b1;
            end
        end
        e_rv = !reset && rsp_q.size() > 0 && rsp_q[0].due == cyc;

        check("req0_ready", 128'(req0_ready), 128'(e_acc && e_id == 0));
        check("req1_ready", 128'(req1_ready), 128'(e_acc && e_id == 1));
        check("bram_en",    128'(bram_en),    128'(e_acc));
        check("bram_we",    128'(bram_we),    128'(e_acc && w[e_id]));
        check("busy",       128'(busy),       128'(!reset && lock_owner >= 0));
        check("grant_id",   128'(grant_id),   128'(reset ? 0 : (e_acc ? e_id : last_grant)));
        check("rsp_valid",  128'(rsp_valid),  128'(e_rv));
        if (e_acc) begin
            check("bram_addr", 128'(bram_addr), 128'(a[e_id]));
            if (w[e_id]) check("bram_din", 128'(bram_din), 128'(d[e_id]));
        end
        if (e_rv) begin
            check("rsp_id",   128'(rsp_id),   128'(rsp_q[0].id));
            check("rsp_data", 128'(rsp_data), 128'(rsp_q[0].data));
        end

        if (reset) begin
            lock_owner = -1;
            favour     = 0;
            last_grant = 0;
            rsp_q.delete();
        end else begin
            if (e_rv) void'(rsp_q.pop_front());
            if (e_acc) begin
                favour     = 1 - e_id;
                last_grant = e_id;
                lock_owner = l[e_id] ? -1 : e_id;
                if (w[e_id]) begin
                    shadow[a[e_id]] = d[e_id];
                end else begin
                    r.due  = cyc + RD_LATENCY;
                    r.id   = (e_id == 1);
                    r.data = shadow[a[e_id]];
                    rsp_q.push_back(r);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input bit w, input bit l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (r == 0) begin
            req0_valid = v; req0_write = w; req0_last = l; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_last = l; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic idle_both();
        set_req(0, 0, 0, 1, '0, '0);
        set_req(1, 0, 0, 1, '0, '0);
    endtask

    localparam logic [DATA_W-1:0] PAT_A5   = {16{8'hA5}};
    localparam logic [DATA_W-1:0] PAT_DEAD = {8{16'hDEAD}};

    initial begin
        int exp_ids [3];
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = {8{16'(i)}};
            shadow[i] = {8{16'(i)}};
        end
        mem[5]    = PAT_A5;
        shadow[5] = PAT_A5;

        reset = 1'b1;
        idle_both();
        step();
        #1;
        check("reset_busy",      128'(busy),      128'(0));
        check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        step();
        reset = 1'b0;

        // Single read by req0 from 0x0005.
        set_req(0, 1, 0, 1, 14'h0005, '0);
        #1;
        check("t1_ready", 128'(req0_ready), 128'(1));
        check("t1_en",    128'(bram_en),    128'(1));
        check("t1_we",    128'(bram_we),    128'(0));
        check("t1_addr",  128'(bram_addr),  128'(14'h0005));
        step();
        idle_both();
        #1;
        check("t1_rsp_valid", 128'(rsp_valid), 128'(1));
        check("t1_rsp_id",    128'(rsp_id),    128'(0));
        check("t1_rsp_data",  128'(rsp_data),  128'(PAT_A5));
        step();

        // Both requesting single beats from a fresh pointer: 0,1,0,1,...
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1, 0, 1, 14'(16'h10 + i), '0);
            set_req(1, 1, 0, 1, 14'(16'h20 + i), '0);
            #1;
            check("t2_r0", 128'(req0_ready), 128'(i % 2 == 0));
            check("t2_r1", 128'(req1_ready), 128'(i % 2 == 1));
            step();
        end
        idle_both();
        step();

        // req1 4-beat write burst locks out a pending req0 read.
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1, 1, k == 3, 14'(16'h100 + k), 128'(32'hB0000 + k));
            if (k > 0) set_req(0, 1, 0, 1, 14'h0101, '0);
            #1;
            check("t3_r1",   128'(req1_ready), 128'(1));
            check("t3_r0",   128'(req0_ready), 128'(0));
            check("t3_busy", 128'(busy),       128'(k > 0));
            step();
        end
        set_req(1, 0, 0, 1, '0, '0);
        #1;
        check("t3_r0_after", 128'(req0_ready), 128'(1));
        check("t3_busy_off", 128'(busy),       128'(0));
        step();
        idle_both();
        #1;
        check("t3_rsp_data", 128'(rsp_data), 128'(32'hB0001));
        step();

        // req0 burst with a 3-cycle bubble; req1 stays locked out.
        set_req(0, 1, 1, 0, 14'h0200, 128'(32'hC0000));
        #1;
        check("t4_r0", 128'(req0_ready), 128'(1));
        step();
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 1, 0, 1, 14'h0020, '0);
        for (int b = 0; b < 3; b++) begin
            #1;
            check("t4_bubble_en", 128'(bram_en),    128'(0));
            check("t4_busy",      128'(busy),       128'(1));
            check("t4_r1",        128'(req1_ready), 128'(0));
            step();
        end
        set_req(0, 1, 1, 1, 14'h0201, 128'(32'hC0001));
        #1;
        check("t4_r0_last", 128'(req0_ready), 128'(1));
        check("t4_r1_last", 128'(req1_ready), 128'(0));
        step();
        set_req(0, 0, 0, 1, '0, '0);
        #1;
        check("t4_r1_after", 128'(req1_ready), 128'(1));
        check("t4_busy_off", 128'(busy),       128'(0));
        step();
        idle_both();
        step();

        // Write top address then read it back the next cycle.
        set_req(1, 1, 1, 1, 14'h3FFF, PAT_DEAD);
        #1;
        check("t5_wr_ready", 128'(req1_ready), 128'(1));
        step();
        set_req(1, 0, 0, 1, '0, '0);
        set_req(0, 1, 0, 1, 14'h3FFF, '0);
        #1;
        check("t5_rd_ready", 128'(req0_ready), 128'(1));
        step();
        // Three back-to-back reads; req1 is favoured after req0's read.
        exp_ids = '{1, 0, 1};
        for (int c = 0; c < 3; c++) begin
            set_req(0, 1, 0, 1, 14'(16'h30 + c), '0);
            set_req(1, 1, 0, 1, 14'(16'h40 + c), '0);
            #1;
            if (c == 0) begin
                check("t5_raw_valid", 128'(rsp_valid), 128'(1));
                check("t5_raw_data",  128'(rsp_data),  128'(PAT_DEAD));
            end else begin
                check("t5_b2b_valid", 128'(rsp_valid), 128'(1));
                check("t5_b2b_id",    128'(rsp_id),    128'(exp_ids[c-1]));
            end
            check("t5_grant", 128'(grant_id), 128'(exp_ids[c]));
            step();
        end
        idle_both();
        #1;
        check("t5_b2b_valid_last", 128'(rsp_valid), 128'(1));
        check("t5_b2b_id_last",    128'(rsp_id),    128'(exp_ids[2]));
        step();
        step();

        // Reset mid-burst with a read in flight.
        set_req(0, 1, 0, 0, 14'h0005, '0);
        #1;
        check("t6_r0", 128'(req0_ready), 128'(1));
        step();
        reset = 1'b1;
        #1;
        check("t6_rsp_valid", 128'(rsp_valid),  128'(0));
        check("t6_busy",      128'(busy),       128'(0));
        check("t6_r0_rst",    128'(req0_ready), 128'(0));
        check("t6_en_rst",    128'(bram_en),    128'(0));
        step();
        check("t6_rsp_valid2", 128'(rsp_valid), 128'(0));
        reset = 1'b0;
        set_req(0, 1, 0, 1, 14'h0001, '0);
        set_req(1, 1, 0, 1, 14'h0002, '0);
        #1;
        check("t6_first_r0", 128'(req0_ready), 128'(1));
        check("t6_first_r1", 128'(req1_ready), 128'(0));
        step();
        idle_both();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
